fpu_scheduler: RTL and testbench

FPU_SCHEDULER -- requirements
Module: fpu_scheduler

---
 rtl/fpu_scheduler.sv | 178 +++++++++++++++++
 tb/tb_fpu_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_scheduler.sv
// fpu_scheduler: round-robin issue of requester operations to one shared
// pipelined FP32 unit, with credit-limited, in-order result return.
module fpu_scheduler #(
  parameter int REQ_COUNT   = 4,
  parameter int FPU_LATENCY = 4,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         EN,
  input  logic [REQ_COUNT-1:0]         REQ_VALID,
  output logic [REQ_COUNT-1:0]         REQ_READY,
  input  logic [2*REQ_COUNT-1:0]       REQ_OP,
  input  logic [32*REQ_COUNT-1:0]      REQ_A,
  input  logic [32*REQ_COUNT-1:0]      REQ_B,
  output logic                         FPU_EN,
  output logic [1:0]                   FPU_OP,
  output logic [31:0]                  FPU_A,
  output logic [31:0]                  FPU_B,
  input  logic                         FPU_VALID,
  input  logic [31:0]                  FPU_RESULT,
  output logic                         RSP_VALID,
  output logic [$clog2(REQ_COUNT)-1:0] RSP_ID,
  output logic [31:0]                  RSP_DATA,
  input  logic                         RSP_READY,
  output logic                         BUSY
);

  localparam int ID_W  = $clog2(REQ_COUNT);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reject parameter sets the credit and pointer arithmetic cannot handle
  if (REQ_COUNT < 2 || REQ_COUNT > 8 || FPU_LATENCY < 1 || FPU_LATENCY > 16 ||
      RSP_DEPTH < 2 || RSP_DEPTH > 16 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_params
    $error("fpu_scheduler: parameter out of supported range");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic              error_flag;

  logic [ID_W-1:0]   tag_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  tag_wr, tag_rd;
  logic [CNT_W-1:0]  tag_count;

  logic [ID_W-1:0]   res_id_mem   [RSP_DEPTH];
  logic [31:0]       res_data_mem [RSP_DEPTH];
  logic [PTR_W-1:0]  res_wr, res_rd;
  logic [CNT_W-1:0]  res_count;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              transfer;
  logic              tag_pop;
  logic              res_pop;
  logic              busy;
  logic [1:0]        sel_op;
  logic [31:0]       sel_a, sel_b;

  assign tag_pop     = FPU_VALID && (tag_count != '0);
  assign RSP_VALID   = (res_count != '0);
  assign res_pop     = RSP_VALID && RSP_READY;
  assign RSP_ID      = RSP_VALID ? res_id_mem[res_rd] : '0;
  assign RSP_DATA    = RSP_VALID ? res_data_mem[res_rd] : '0;
  assign busy        = (tag_count != '0) || (res_count != '0) || FPU_EN;
  assign BUSY        = busy;
  assign credit_used = {1'b0, tag_count} + {1'b0, res_count} - {{CNT_W{1'b0}}, res_pop};
  assign credit_ok   = credit_used < (CNT_W + 1)'(RSP_DEPTH);
  assign transfer    = (state == RUN) && EN && credit_ok && grant_found;

  // Round-robin search for the first valid requester starting at ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(REQ_COUNT)) cand = cand - (ID_W + 1)'(REQ_COUNT);
      if (!grant_found && REQ_VALID[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // One-hot grant for the selected requester when issue is allowed
  always_comb begin
    REQ_READY = '0;
    if (transfer) REQ_READY[grant_idx] = 1'b1;
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = REQ_OP[2*i +: 2];
        sel_a  = REQ_A[32*i +: 32];
        sel_b  = REQ_B[32*i +: 32];
      end
    end
  end

  // Scheduler mode: grants only in RUN, DRAIN finishes outstanding work
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (EN) state <= RUN;
        RUN:     if (!EN) state <= busy ? DRAIN : IDLE;
        DRAIN:   if (EN) state <= RUN;
                 else if (!busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered issue to the FP unit and round-robin pointer advance
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      FPU_EN <= 1'b0;
      FPU_OP <= '0;
      FPU_A  <= '0;
      FPU_B  <= '0;
      ptr    <= '0;
    end else begin
      FPU_EN <= transfer;
      if (transfer) begin
        FPU_OP <= sel_op;
        FPU_A  <= sel_a;
        FPU_B  <= sel_b;
        ptr    <= (grant_idx == ID_W'(REQ_COUNT - 1)) ? '0 : grant_idx + ID_W'(1);
      end
    end
  end

  // Tag and result FIFO bookkeeping plus the stray-result error flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_wr     <= '0;
      tag_rd     <= '0;
      tag_count  <= '0;
      res_wr     <= '0;
      res_rd     <= '0;
      res_count  <= '0;
      error_flag <= 1'b0;
    end else begin
      if (transfer) tag_wr <= tag_wr + PTR_W'(1);
      if (tag_pop) begin
        tag_rd <= tag_rd + PTR_W'(1);
        res_wr <= res_wr + PTR_W'(1);
      end
      if (res_pop) res_rd <= res_rd + PTR_W'(1);
      tag_count <= tag_count + CNT_W'(transfer) - CNT_W'(tag_pop);
      res_count <= res_count + CNT_W'(tag_pop) - CNT_W'(res_pop);
      if (FPU_VALID && (tag_count == '0)) error_flag <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the counts gate every read
  always_ff @(posedge CLK) begin
    if (transfer) tag_mem[tag_wr] <= grant_idx;
    if (tag_pop) begin
      res_id_mem[res_wr]   <= tag_mem[tag_rd];
      res_data_mem[res_wr] <= FPU_RESULT;
    end
  end

endmodule

// File: tb/tb_fpu_scheduler.sv
// tb_fpu_scheduler: self-checking bench for fpu_scheduler with a fixed-latency
// stand-in FP unit and a response scoreboard.
module tb_fpu_scheduler;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             EN;
  logic [N-1:0]     REQ_VALID;
  logic [N-1:0]     REQ_READY;
  logic [2*N-1:0]   REQ_OP;
  logic [32*N-1:0]  REQ_A;
  logic [32*N-1:0]  REQ_B;
  logic             FPU_EN;
  logic [1:0]       FPU_OP;
  logic [31:0]      FPU_A;
  logic [31:0]      FPU_B;
  logic             FPU_VALID;
  logic [31:0]      FPU_RESULT;
  logic             RSP_VALID;
  logic [IDW-1:0]   RSP_ID;
  logic [31:0]      RSP_DATA;
  logic             RSP_READY;
  logic             BUSY;

  int checks   = 0;
  int fails    = 0;
  int rspSeen  = 0;

  fpu_scheduler #(.REQ_COUNT(N), .FPU_LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .FPU_EN(FPU_EN), .FPU_OP(FPU_OP), .FPU_A(FPU_A), .FPU_B(FPU_B),
    .FPU_VALID(FPU_VALID), .FPU_RESULT(FPU_RESULT),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
    .RSP_READY(RSP_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Deterministic stand-in for the FP unit; op 0 on 1.0 and 2.0 gives 3.0
  function automatic logic [31:0] fpuModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    fpuModel = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : (a ^ b);
      2'd1:    fpuModel = a + b;
      2'd2:    fpuModel = a - b;
      default: fpuModel = ~a ^ b;
    endcase
  endfunction

  logic [LAT-1:0] pipeValid = '0;
  logic [31:0]    pipeData [LAT];

  // Fixed-latency FP unit pipeline, deliberately not cleared by nRST
  always @(posedge CLK) begin
    pipeValid   <= {pipeValid[LAT-2:0], FPU_EN};
    pipeData[0] <= fpuModel(FPU_OP, FPU_A, FPU_B);
    for (int i = 1; i < LAT; i++) pipeData[i] <= pipeData[i-1];
  end

  assign FPU_VALID  = pipeValid[LAT-1];
  assign FPU_RESULT = pipeData[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [N-1:0] valid, input logic rdy);
    @(negedge CLK);
    EN        = en;
    REQ_VALID = valid;
    RSP_READY = rdy;
  endtask

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } rsp_t;

  rsp_t expQ [$];
  rsp_t popE;
  rsp_t pushE;

  // Scoreboard: push on each accepted request, pop and compare on each response
  always begin
    @(negedge CLK);
    #2;
    if (!nRST) begin
      expQ.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (REQ_VALID[i] && REQ_READY[i]) begin
          pushE.id   = IDW'(i);
          pushE.data = fpuModel(REQ_OP[2*i +: 2], REQ_A[32*i +: 32], REQ_B[32*i +: 32]);
          expQ.push_back(pushE);
        end
      end
      if (RSP_VALID && RSP_READY) begin
        rspSeen++;
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL rsp_unexpected: got id %0d data 0x%08h, required no response", RSP_ID, RSP_DATA);
        end else begin
          popE = expQ.pop_front();
          checkOutput("rsp_id", 64'(RSP_ID), 64'(popE.id));
          checkOutput("rsp_data", 64'(RSP_DATA), 64'(popE.data));
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    logic         fpuEn;
  } vec_t;

  vec_t vecs [12];

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;
    int cyc;
    int seenBefore;

    // Round-robin table: pointer is 3 on entry (requester 2 was last granted)
    vecs[0]  = '{4'b1111, 4'b1000, 1'b0};
    vecs[1]  = '{4'b1111, 4'b0001, 1'b1};
    vecs[2]  = '{4'b1111, 4'b0010, 1'b1};
    vecs[3]  = '{4'b1111, 4'b0100, 1'b1};
    vecs[4]  = '{4'b1111, 4'b1000, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0001, 1'b1};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b1};
    vecs[7]  = '{4'b0001, 4'b0001, 1'b0};
    vecs[8]  = '{4'b1001, 4'b1000, 1'b1};
    vecs[9]  = '{4'b0110, 4'b0010, 1'b1};
    vecs[10] = '{4'b0010, 4'b0010, 1'b1};
    vecs[11] = '{4'b1100, 4'b0100, 1'b1};

    nRST      = 1'b1;
    EN        = 1'b0;
    REQ_VALID = '0;
    RSP_READY = 1'b0;
    REQ_OP    = {2'd2, 2'd0, 2'd3, 2'd1};
    for (int i = 0; i < N; i++) begin
      REQ_A[32*i +: 32] = 32'(i + 1) * 32'h1000_0000 + 32'h55;
      REQ_B[32*i +: 32] = 32'(i + 1) * 32'h0000_1111;
    end
    REQ_A[64 +: 32] = 32'h3F80_0000;
    REQ_B[64 +: 32] = 32'h4000_0000;

    #1 nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("reset_req_ready", 64'(REQ_READY), 64'(0));
    checkOutput("reset_fpu_en", 64'(FPU_EN), 64'(0));
    checkOutput("reset_fpu_op", 64'(FPU_OP), 64'(0));
    checkOutput("reset_fpu_a", 64'(FPU_A), 64'(0));
    checkOutput("reset_fpu_b", 64'(FPU_B), 64'(0));
    checkOutput("reset_rsp_valid", 64'(RSP_VALID), 64'(0));
    checkOutput("reset_rsp_id", 64'(RSP_ID), 64'(0));
    checkOutput("reset_rsp_data", 64'(RSP_DATA), 64'(0));
    checkOutput("reset_busy", 64'(BUSY), 64'(0));
    checkOutput("reset_state", 64'(dut.state), 64'(ST_IDLE));
    checkOutput("reset_error", 64'(dut.error_flag), 64'(0));
    @(negedge CLK);
    nRST = 1'b1;

    // Single operation from requester 2
    applyStimulus(1'b1, 4'b0100, 1'b0);
    #1 checkOutput("idle_no_grant", 64'(REQ_READY), 64'(0));
    applyStimulus(1'b1, 4'b0100, 1'b0);
    #1 checkOutput("single_grant", 64'(REQ_READY), 64'(4'b0100));
    applyStimulus(1'b1, 4'b0000, 1'b0);
    #1;
    checkOutput("single_fpu_en", 64'(FPU_EN), 64'(1));
    checkOutput("single_fpu_op", 64'(FPU_OP), 64'(0));
    checkOutput("single_fpu_a", 64'(FPU_A), 64'(32'h3F80_0000));
    checkOutput("single_fpu_b", 64'(FPU_B), 64'(32'h4000_0000));
    checkOutput("single_busy", 64'(BUSY), 64'(1));
    for (int c = 1; c <= LAT + 1; c++) begin
      applyStimulus(1'b1, 4'b0000, 1'b0);
      #1;
      if (c == 1) checkOutput("single_fpu_en_pulse", 64'(FPU_EN), 64'(0));
      if (c <= LAT) checkOutput("single_rsp_early", 64'(RSP_VALID), 64'(0));
    end
    checkOutput("single_rsp_valid", 64'(RSP_VALID), 64'(1));
    checkOutput("single_rsp_id", 64'(RSP_ID), 64'(2));
    checkOutput("single_rsp_data", 64'(RSP_DATA), 64'(32'h4040_0000));
    applyStimulus(1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    #1;
    checkOutput("single_rsp_popped", 64'(RSP_VALID), 64'(0));
    checkOutput("single_busy_low", 64'(BUSY), 64'(0));

    // Round-robin fairness and back-to-back issue
    for (int v = 0; v < 12; v++) begin
      applyStimulus(1'b1, vecs[v].valid, 1'b1);
      #1;
      checkOutput($sformatf("rr_ready_%0d", v), 64'(REQ_READY), 64'(vecs[v].ready));
      checkOutput($sformatf("rr_fpu_en_%0d", v), 64'(FPU_EN), 64'(vecs[v].fpuEn));
    end
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 4'b0000, 1'b1);
    #1;
    checkOutput("rr_drained_busy", 64'(BUSY), 64'(0));
    checkOutput("rr_scoreboard_empty", 64'(expQ.size()), 64'(0));

    // Backpressure: credit stops grants at DEPTH outstanding results
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      #1;
      if (REQ_READY != '0) grants++;
    end
    checkOutput("bp_grant_count", 64'(grants), 64'(DEPTH));
    checkOutput("bp_ready_blocked", 64'(REQ_READY), 64'(0));
    applyStimulus(1'b1, 4'b1111, 1'b1);
    #1 checkOutput("bp_pop_frees_credit", 64'(REQ_READY), 64'(4'b1000));
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      #1;
      if (REQ_READY != '0) grants++;
    end
    checkOutput("bp_single_extra_grant", 64'(grants), 64'(0));
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 4'b0000, 1'b1);
    #1;
    checkOutput("bp_drained_busy", 64'(BUSY), 64'(0));
    checkOutput("bp_scoreboard_empty", 64'(expQ.size()), 64'(0));

    // Drain: three ops in flight, EN dropped, responses still delivered
    seenBefore = rspSeen;
    applyStimulus(1'b1, 4'b0111, 1'b0);
    #1 checkOutput("drain_issue_0", 64'(REQ_READY), 64'(4'b0001));
    applyStimulus(1'b1, 4'b0111, 1'b0);
    #1 checkOutput("drain_issue_1", 64'(REQ_READY), 64'(4'b0010));
    applyStimulus(1'b1, 4'b0111, 1'b0);
    #1 checkOutput("drain_issue_2", 64'(REQ_READY), 64'(4'b0100));
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #1 checkOutput("drain_en_low_no_grant", 64'(REQ_READY), 64'(0));
    applyStimulus(1'b0, 4'b1111, 1'b1);
    #1;
    checkOutput("drain_state", 64'(dut.state), 64'(ST_DRAIN));
    checkOutput("drain_busy", 64'(BUSY), 64'(1));
    grants = (REQ_READY != '0) ? 1 : 0;
    cyc = 0;
    while (BUSY && cyc < 20) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      #1;
      if (REQ_READY != '0) grants++;
      cyc++;
    end
    checkOutput("drain_busy_fell", 64'(cyc < 20), 64'(1));
    checkOutput("drain_no_grants", 64'(grants), 64'(0));
    applyStimulus(1'b0, 4'b0000, 1'b1);
    #1;
    checkOutput("drain_to_idle", 64'(dut.state), 64'(ST_IDLE));
    checkOutput("drain_rsp_count", 64'(rspSeen - seenBefore), 64'(3));

    // Reset with two operations in flight; the late result must be dropped
    applyStimulus(1'b1, 4'b0011, 1'b1);
    applyStimulus(1'b1, 4'b0011, 1'b1);
    #1 checkOutput("rst_issue_0", 64'(REQ_READY), 64'(4'b0001));
    applyStimulus(1'b1, 4'b0011, 1'b1);
    #1;
    checkOutput("rst_issue_1", 64'(REQ_READY), 64'(4'b0010));
    checkOutput("rst_busy_before", 64'(BUSY), 64'(1));
    @(negedge CLK);
    EN        = 1'b0;
    REQ_VALID = '0;
    nRST      = 1'b0;
    #1;
    checkOutput("rst_mid_req_ready", 64'(REQ_READY), 64'(0));
    checkOutput("rst_mid_fpu_en", 64'(FPU_EN), 64'(0));
    checkOutput("rst_mid_fpu_op", 64'(FPU_OP), 64'(0));
    checkOutput("rst_mid_fpu_a", 64'(FPU_A), 64'(0));
    checkOutput("rst_mid_fpu_b", 64'(FPU_B), 64'(0));
    checkOutput("rst_mid_rsp_valid", 64'(RSP_VALID), 64'(0));
    checkOutput("rst_mid_rsp_id", 64'(RSP_ID), 64'(0));
    checkOutput("rst_mid_rsp_data", 64'(RSP_DATA), 64'(0));
    checkOutput("rst_mid_busy", 64'(BUSY), 64'(0));
    checkOutput("rst_mid_state", 64'(dut.state), 64'(ST_IDLE));
    checkOutput("rst_mid_error", 64'(dut.error_flag), 64'(0));
    #2 nRST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1);
      #1 checkOutput($sformatf("rst_late_rsp_%0d", c), 64'(RSP_VALID), 64'(0));
    end
    checkOutput("rst_error_flag", 64'(dut.error_flag), 64'(1));
    checkOutput("final_scoreboard_empty", 64'(expQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
